dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, 1024, RAM size in 32-bit words (power of two).
REQ-002 Parameter MMIO_BASE, 32'h1000_0000, base address of register window.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 mem_address  input  32  byte address from core MEM stage.
REQ-006 mem_write_data  input  32  store data.
REQ-007 mem_write_en  input  1  store strobe, one access per cycle high.
REQ-008 mem_read_en  input  1  load strobe, one access per cycle high.
REQ-009 mem_read_data  output  32  load data, combinational from address.
REQ-010 gpio_out  output  32  GPIO_OUT register value.
REQ-011 timer_irq  output  1  timer interrupt pending flag.

Function
REQ-012 RAM region SHALL be 0 to DEPTH_WORDS*4-1; MMIO region SHALL be MMIO_BASE to MMIO_BASE+0x1F; all other addresses are unmapped.
REQ-013 Read latency SHALL be zero: mem_read_data valid in the same cycle as mem_read_en; mem_read_data SHALL be 0 when mem_read_en is low.
REQ-014 Writes SHALL commit at the rising edge where mem_write_en is high and be visible to reads from the next cycle.
REQ-015 A read and write to the same address in the same cycle SHALL return the pre-write value.
REQ-016 MMIO map (offset, access): 0x00 GPIO_OUT RW; 0x04 CYCLE_LO RO; 0x08 CYCLE_HI RO; 0x0C TIMER_CMP RW; 0x10 TIMER_CTRL RW; 0x14 ERR_COUNT RO; 0x18 ERR_ADDR RO; 0x1C TIMER_CNT RO.
REQ-017 Writes to RO registers SHALL be ignored without counting as errors.
REQ-018 64-bit cycle counter SHALL increment every cycle, wrapping at 2^64-1 to 0.
REQ-019 A read of CYCLE_LO SHALL capture counter[63:32] into a snapshot register at that edge; CYCLE_HI reads SHALL return the snapshot.
REQ-020 TIMER_CTRL bit0 = enable (RW); bit1 = pending (read, write-1-to-clear); other bits read 0.
REQ-021 TIMER_CNT SHALL increment by 1 per cycle while enable=1, wrapping to 0 after 0xFFFF_FFFF; a write to TIMER_CMP SHALL clear TIMER_CNT to 0 at that edge.
REQ-022 pending SHALL set on the edge after TIMER_CNT == TIMER_CMP with enable=1; if set and W1C coincide, set wins.
REQ-023 timer_irq SHALL equal pending.
REQ-024 An access (read_en or write_en) with mem_address[1:0] != 0 or to an unmapped address is an error: write suppressed, read returns 0.
REQ-025 On error, ERR_COUNT SHALL increment, saturating at 0xFFFF_FFFF, and ERR_ADDR SHALL load mem_address.
REQ-026 read_en and write_en both high SHALL perform the write, return pre-write data, and count at most one error.

Reset
REQ-027 While rst_n is low: gpio_out=0, timer_irq=0, cycle counter=0, snapshot=0, TIMER_CMP=0xFFFF_FFFF, TIMER_CNT=0, enable=0, ERR_COUNT=0, ERR_ADDR=0.
REQ-028 RAM contents SHALL not be reset; reset asserted mid-operation SHALL abort any write on that cycle.
REQ-029 mem_read_data SHALL remain combinational during reset (0 unless mem_read_en is high).

Structure
REQ-030 Region bounds, MMIO offsets, TIMER_CTRL bit positions and the CMP reset value SHALL live in rv32_pipeline_pkg.
REQ-031 RAM array SHALL be sub-module dmem_ram (async read, sync write, DEPTH_WORDS words); registers and decode SHALL stay in dmem_responder.

Verification
REQ-032 Write 0xCAFE_F00D to 0x0000_0010, read next cycle -> 0xCAFE_F00D; same-cycle read of 0x10 with a write of 0x1234_5678 -> 0xCAFE_F00D.
REQ-033 Write 0x0000_00A5 to MMIO_BASE+0x00 -> gpio_out=0x0000_00A5 next cycle; write to MMIO_BASE+0x04 -> CYCLE_LO unchanged, ERR_COUNT unchanged.
REQ-034 Force counter to 0x0000_0000_FFFF_FFFF, read CYCLE_LO -> 0xFFFF_FFFF, next-cycle read CYCLE_HI -> 0x0000_0000 (snapshot, not 1).
REQ-035 TIMER_CMP=5, enable=1 -> timer_irq rises 6 cycles after the CMP write; write TIMER_CTRL=0x3 -> pending cleared, enable kept.
REQ-036 Read 0x0000_0002 then write 0x2000_0000 -> read data 0, ERR_COUNT=2, ERR_ADDR=0x2000_0000, RAM unchanged.
REQ-037 Assert rst_n low mid-write to 0x20 -> write dropped, all registers at REQ-027 values, prior RAM data retained.

Source files
------------

// File: rtl/rv32_pipeline_pkg.sv
// Shared constants for the data-memory responder: region bounds, the MMIO
// register map, TIMER_CTRL bit positions and register reset values.
// No ports; imported by dmem_responder.
package rv32_pipeline_pkg;

    // RAM region starts at address 0; its size comes from DEPTH_WORDS.
    localparam logic [31:0] DMEM_RAM_BASE          = 32'h0000_0000;
    // Default base of the 32-byte register window.
    localparam logic [31:0] DMEM_MMIO_BASE_DEFAULT = 32'h1000_0000;
    // The register window spans 2**DMEM_MMIO_SPAN_BITS bytes.
    localparam int unsigned DMEM_MMIO_SPAN_BITS    = 5;

    // Byte offsets inside the register window.
    localparam logic [4:0] MMIO_OFF_GPIO_OUT   = 5'h00;
    localparam logic [4:0] MMIO_OFF_CYCLE_LO   = 5'h04;
    localparam logic [4:0] MMIO_OFF_CYCLE_HI   = 5'h08;
    localparam logic [4:0] MMIO_OFF_TIMER_CMP  = 5'h0C;
    localparam logic [4:0] MMIO_OFF_TIMER_CTRL = 5'h10;
    localparam logic [4:0] MMIO_OFF_ERR_COUNT  = 5'h14;
    localparam logic [4:0] MMIO_OFF_ERR_ADDR   = 5'h18;
    localparam logic [4:0] MMIO_OFF_TIMER_CNT  = 5'h1C;

    // TIMER_CTRL fields.
    localparam int unsigned TIMER_CTRL_EN_BIT   = 0;
    localparam int unsigned TIMER_CTRL_PEND_BIT = 1;

    // Reset value of TIMER_CMP and saturation limit of ERR_COUNT.
    localparam logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF;
    localparam logic [31:0] ERR_COUNT_MAX = 32'hFFFF_FFFF;

    // A word access must have its two byte-offset bits clear.
    function automatic logic word_misaligned(input logic [1:0] byte_off);
        return (byte_off != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed data RAM: asynchronous read, synchronous write, no reset.
// Ports:
//   clk   - write clock
//   we    - write enable, commits wdata at the rising edge
//   addr  - word index, shared by the read and write ports
//   wdata - store data
//   rdata - combinational read of the word at addr (pre-write value)
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_BITS   = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];

    // Synchronous write port; contents are intentionally never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // A same-cycle read sees the old word because the write lands at the edge.
    assign rdata = mem_r[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the core MEM stage: word RAM plus a small
// register window (GPIO, 64-bit cycle counter with snapshot, compare timer,
// access-error log).
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   mem_address     - byte address of the access
//   mem_write_data  - store data
//   mem_write_en    - store strobe
//   mem_read_en     - load strobe
//   mem_read_data   - load data, combinational, 0 when not reading or on error
//   gpio_out        - GPIO_OUT register
//   timer_irq       - timer pending flag
module dmem_responder
    import rv32_pipeline_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = DMEM_MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_write_data,
    input  logic        mem_write_en,
    input  logic        mem_read_en,
    output logic [31:0] mem_read_data,
    output logic [31:0] gpio_out,
    output logic        timer_irq
);

    localparam int unsigned ADDR_BITS   = $clog2(DEPTH_WORDS);
    localparam int unsigned RAM_TOP_LSB = ADDR_BITS + 2;

    // Decode
    logic [4:0]  offset_s;
    logic        misaligned_s;
    logic        ram_hit_s;
    logic        mmio_hit_s;
    logic        access_s;
    logic        err_s;
    logic        ram_we_s;
    logic        mmio_we_s;
    logic        mmio_re_s;
    logic        gpio_wr_s;
    logic        cmp_wr_s;
    logic        ctrl_wr_s;
    logic        cyc_lo_rd_s;
    logic        timer_hit_s;

    // Read path
    logic [31:0] ram_rdata_s;
    logic [31:0] mmio_rdata_s;
    logic [31:0] ctrl_rdata_s;

    // Registers
    logic [31:0] gpio_r;
    logic [63:0] cycle_r;
    logic [31:0] snap_r;
    logic [31:0] cmp_r;
    logic [31:0] cnt_r;
    logic        en_r;
    logic        pend_r;
    logic [31:0] err_cnt_r;
    logic [31:0] err_addr_r;

    // Address decode, error detection and per-register strobes.
    always_comb begin
        offset_s     = mem_address[DMEM_MMIO_SPAN_BITS-1:0];
        misaligned_s = word_misaligned(mem_address[1:0]);
        ram_hit_s    = (mem_address[31:RAM_TOP_LSB] == DMEM_RAM_BASE[31:RAM_TOP_LSB]);
        mmio_hit_s   = (mem_address[31:DMEM_MMIO_SPAN_BITS] == MMIO_BASE[31:DMEM_MMIO_SPAN_BITS]);
        access_s     = mem_read_en | mem_write_en;
        // A combined read+write is one access, so it logs at most one error.
        err_s        = access_s & (misaligned_s | ~(ram_hit_s | mmio_hit_s));
        // rst_n gates the RAM strobe so a reset arriving mid-store drops it.
        ram_we_s     = mem_write_en & ram_hit_s & ~misaligned_s & rst_n;
        mmio_we_s    = mem_write_en & mmio_hit_s & ~misaligned_s;
        mmio_re_s    = mem_read_en & mmio_hit_s & ~misaligned_s;
        gpio_wr_s    = mmio_we_s & (offset_s == MMIO_OFF_GPIO_OUT);
        cmp_wr_s     = mmio_we_s & (offset_s == MMIO_OFF_TIMER_CMP);
        ctrl_wr_s    = mmio_we_s & (offset_s == MMIO_OFF_TIMER_CTRL);
        cyc_lo_rd_s  = mmio_re_s & (offset_s == MMIO_OFF_CYCLE_LO);
        timer_hit_s  = en_r & (cnt_r == cmp_r);
    end

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_BITS   (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (mem_address[RAM_TOP_LSB-1:2]),
        .wdata (mem_write_data),
        .rdata (ram_rdata_s)
    );

    // TIMER_CTRL read image: enable and pending, all other bits zero.
    always_comb begin
        ctrl_rdata_s                      = 32'd0;
        ctrl_rdata_s[TIMER_CTRL_EN_BIT]   = en_r;
        ctrl_rdata_s[TIMER_CTRL_PEND_BIT] = pend_r;
    end

    // Register-window read mux and final load-data select.
    always_comb begin
        case (offset_s)
            MMIO_OFF_GPIO_OUT:   mmio_rdata_s = gpio_r;
            MMIO_OFF_CYCLE_LO:   mmio_rdata_s = cycle_r[31:0];
            MMIO_OFF_CYCLE_HI:   mmio_rdata_s = snap_r;
            MMIO_OFF_TIMER_CMP:  mmio_rdata_s = cmp_r;
            MMIO_OFF_TIMER_CTRL: mmio_rdata_s = ctrl_rdata_s;
            MMIO_OFF_ERR_COUNT:  mmio_rdata_s = err_cnt_r;
            MMIO_OFF_ERR_ADDR:   mmio_rdata_s = err_addr_r;
            MMIO_OFF_TIMER_CNT:  mmio_rdata_s = cnt_r;
            default:             mmio_rdata_s = 32'd0;
        endcase

        if (!mem_read_en || err_s) begin
            mem_read_data = 32'd0;
        end else if (mmio_hit_s) begin
            mem_read_data = mmio_rdata_s;
        end else begin
            mem_read_data = ram_rdata_s;
        end
    end

    // GPIO output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_r <= 32'd0;
        end else if (gpio_wr_s) begin
            gpio_r <= mem_write_data;
        end
    end

    // Free-running cycle counter; a CYCLE_LO read freezes the upper half so
    // a following CYCLE_HI read pairs with the low half already returned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_r <= 64'd0;
            snap_r  <= 32'd0;
        end else begin
            cycle_r <= cycle_r + 64'd1;
            if (cyc_lo_rd_s) begin
                snap_r <= cycle_r[63:32];
            end
        end
    end

    // Compare timer: counter, compare value, enable and sticky pending flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_r  <= TIMER_CMP_RST;
            cnt_r  <= 32'd0;
            en_r   <= 1'b0;
            pend_r <= 1'b0;
        end else begin
            if (cmp_wr_s) begin
                cmp_r <= mem_write_data;
                cnt_r <= 32'd0;
            end else if (en_r) begin
                cnt_r <= cnt_r + 32'd1;
            end
            if (ctrl_wr_s) begin
                en_r <= mem_write_data[TIMER_CTRL_EN_BIT];
            end
            // A match in the same cycle as a write-1-to-clear keeps the flag.
            if (timer_hit_s) begin
                pend_r <= 1'b1;
            end else if (ctrl_wr_s && mem_write_data[TIMER_CTRL_PEND_BIT]) begin
                pend_r <= 1'b0;
            end
        end
    end

    // Access-error log: saturating count and address of the latest error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_r  <= 32'd0;
            err_addr_r <= 32'd0;
        end else if (err_s) begin
            if (err_cnt_r != ERR_COUNT_MAX) begin
                err_cnt_r <= err_cnt_r + 32'd1;
            end
            err_addr_r <= mem_address;
        end
    end

    assign gpio_out  = gpio_r;
    assign timer_irq = pend_r;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam logic [31:0] MB = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [31:0] mem_read_data;
    logic [31:0] gpio_out;
    logic        timer_irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [63:0] model_cycle;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .MMIO_BASE   (MB)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write_en   (mem_write_en),
        .mem_read_en    (mem_read_en),
        .mem_read_data  (mem_read_data),
        .gpio_out       (gpio_out),
        .timer_irq      (timer_irq)
    );

    always #5 clk = ~clk;

    // Reference cycle count, valid until the counter is forced.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_cycle <= 64'd0;
        else        model_cycle <= model_cycle + 64'd1;
    end

    // Present one access for one cycle; returns just after the falling edge.
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we, input logic re);
        @(negedge clk);
        mem_address    = a;
        mem_write_data = d;
        mem_write_en   = we;
        mem_read_en    = re;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_v;
        logic [31:0] ra [7] = '{MB + 32'h04, MB + 32'h08, MB + 32'h0C, MB + 32'h10, MB + 32'h14, MB + 32'h18, MB + 32'h1C};
        logic [31:0] re [7] = '{32'd1, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (gpio_out !== 32'd0) begin n_fail++; $display("FAIL rst_gpio got=%h exp=%h", gpio_out, 32'd0); end
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq got=%b exp=0", timer_irq); end
        n_checks++; if (mem_read_data !== 32'd0) begin n_fail++; $display("FAIL rst_rdata_idle got=%h exp=0", mem_read_data); end
        exp_q.push_back(32'hFFFF_FFFF);
        drive(MB + 32'h0C, 32'd0, 1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL rst_cmp_in_reset got=%h exp=%h", mem_read_data, exp_v); end
        @(negedge clk);
        mem_read_en = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(re[i]);
            drive(ra[i], 32'd0, 1'b0, 1'b1);
            exp_v = exp_q.pop_front();
            n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL rst_reg_%0d got=%h exp=%h", i, mem_read_data, exp_v); end
        end
    endtask

    task automatic test_ram();
        logic [31:0] exp_v;
        logic [31:0] a;
        logic [31:0] d;
        drive(32'h10, 32'hCAFE_F00D, 1'b1, 1'b0);
        exp_q.push_back(32'hCAFE_F00D);
        drive(32'h10, 32'd0, 1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL ram_readback got=%h exp=%h", mem_read_data, exp_v); end
        exp_q.push_back(32'hCAFE_F00D);
        drive(32'h10, 32'h1234_5678, 1'b1, 1'b1);
        exp_v = exp_q.pop_front();
        n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL ram_rw_prewrite got=%h exp=%h", mem_read_data, exp_v); end
        exp_q.push_back(32'h1234_5678);
        drive(32'h10, 32'd0, 1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL ram_rw_after got=%h exp=%h", mem_read_data, exp_v); end
        // Burst of writes (last one at the top RAM word), then read all back.
        for (int i = 0; i < 7; i++) begin
            a = (i == 6) ? 32'h0000_0FFC : 32'h100 + 32'(i) * 32'd4;
            d = $urandom;
            exp_q.push_back(d);
            drive(a, d, 1'b1, 1'b0);
        end
        for (int i = 0; i < 7; i++) begin
            a = (i == 6) ? 32'h0000_0FFC : 32'h100 + 32'(i) * 32'd4;
            drive(a, 32'd0, 1'b0, 1'b1);
            exp_v = exp_q.pop_front();
            n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL ram_burst_%0d got=%h exp=%h", i, mem_read_data, exp_v); end
        end
        drive(32'd0, 32'd0, 1'b0, 1'b0);
        n_checks++; if (mem_read_data !== 32'd0) begin n_fail++; $display("FAIL ram_no_read_zero got=%h exp=0", mem_read_data); end
    endtask

    task automatic test_gpio_ro();
        logic [31:0] exp_v;
        drive(MB, 32'h0000_00A5, 1'b1, 1'b0);
        exp_q.push_back(32'h0000_00A5);
        drive(MB, 32'd0, 1'b0, 1'b1);
        n_checks++; if (gpio_out !== 32'h0000_00A5) begin n_fail++; $display("FAIL gpio_out got=%h exp=%h", gpio_out, 32'h0000_00A5); end
        exp_v = exp_q.pop_front();
        n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL gpio_read got=%h exp=%h", mem_read_data, exp_v); end
        drive(MB + 32'h04, 32'hDEAD_BEEF, 1'b1, 1'b0);
        drive(MB + 32'h14, 32'h0000_0077, 1'b1, 1'b0);
        drive(MB + 32'h04, 32'd0, 1'b0, 1'b1);
        exp_q.push_back(model_cycle[31:0]);
        exp_v = exp_q.pop_front();
        n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL ro_cycle_lo got=%h exp=%h", mem_read_data, exp_v); end
        exp_q.push_back(32'd0);
        drive(MB + 32'h14, 32'd0, 1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL ro_err_count got=%h exp=%h", mem_read_data, exp_v); end
    endtask

    task automatic test_cycle_snapshot();
        logic [31:0] exp_v;
        logic [31:0] ra [4] = '{MB + 32'h08, MB + 32'h04, MB + 32'h08, MB + 32'h04};
        logic [31:0] e1 [4] = '{32'd0, 32'd1, 32'd1, 32'd0};
        logic [31:0] e2 [4] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0};
        // Carry out of the low word: snapshot must keep the pre-carry high half.
        @(negedge clk);
        force dut.cycle_r = 64'h0000_0000_FFFF_FFFF;
        mem_address = MB + 32'h04; mem_write_en = 1'b0; mem_read_en = 1'b1;
        #1;
        n_checks++; if (mem_read_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cyc_lo_forced got=%h exp=FFFFFFFF", mem_read_data); end
        release dut.cycle_r;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(e1[i]);
            drive(ra[i], 32'd0, 1'b0, 1'b1);
            exp_v = exp_q.pop_front();
            n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL cyc_carry_%0d got=%h exp=%h", i, mem_read_data, exp_v); end
        end
        // 64-bit wrap to zero.
        @(negedge clk);
        force dut.cycle_r = 64'hFFFF_FFFF_FFFF_FFFF;
        mem_address = MB + 32'h04; mem_write_en = 1'b0; mem_read_en = 1'b1;
        #1;
        n_checks++; if (mem_read_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cyc_lo_allones got=%h exp=FFFFFFFF", mem_read_data); end
        release dut.cycle_r;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(e2[i]);
            drive(ra[i], 32'd0, 1'b0, 1'b1);
            exp_v = exp_q.pop_front();
            n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL cyc_wrap_%0d got=%h exp=%h", i, mem_read_data, exp_v); end
        end
    endtask

    task automatic test_timer();
        logic [31:0] exp_v;
        drive(MB + 32'h10, 32'h1, 1'b1, 1'b0);
        drive(MB + 32'h0C, 32'd5, 1'b1, 1'b0);
        for (int k = 0; k < 7; k++) begin
            exp_q.push_back(32'(k));
            drive(MB + 32'h1C, 32'd0, 1'b0, 1'b1);
            exp_v = exp_q.pop_front();
            n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL timer_cnt_%0d got=%h exp=%h", k, mem_read_data, exp_v); end
            n_checks++; if (timer_irq !== (k == 6)) begin n_fail++; $display("FAIL timer_irq_%0d got=%b exp=%b", k, timer_irq, (k == 6)); end
        end
        exp_q.push_back(32'h3);
        drive(MB + 32'h10, 32'd0, 1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL timer_ctrl_pend got=%h exp=%h", mem_read_data, exp_v); end
        drive(MB + 32'h10, 32'h3, 1'b1, 1'b0);
        exp_q.push_back(32'h1);
        drive(MB + 32'h10, 32'd0, 1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL timer_w1c got=%h exp=%h", mem_read_data, exp_v); end
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL timer_irq_cleared got=%b exp=0", timer_irq); end
        // Clear coinciding with a match: the set must win.
        drive(MB + 32'h0C, 32'd2, 1'b1, 1'b0);
        drive(MB + 32'h1C, 32'd0, 1'b0, 1'b1);
        drive(MB + 32'h1C, 32'd0, 1'b0, 1'b1);
        drive(MB + 32'h10, 32'h3, 1'b1, 1'b0);
        exp_q.push_back(32'h3);
        drive(MB + 32'h10, 32'd0, 1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL timer_set_wins got=%h exp=%h", mem_read_data, exp_v); end
        n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL timer_set_wins_irq got=%b exp=1", timer_irq); end
        // Disable without clearing; pending stays for the reset test.
        drive(MB + 32'h10, 32'h0, 1'b1, 1'b0);
        exp_q.push_back(32'h2);
        drive(MB + 32'h10, 32'd0, 1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL timer_disable got=%h exp=%h", mem_read_data, exp_v); end
    endtask

    task automatic test_errors();
        logic [31:0] exp_v;
        logic [31:0] ra [11] = '{32'h2, MB + 32'h14, MB + 32'h18, 32'h0, 32'h1003, MB + 32'h14, MB + 32'h18,
                                 32'h0, MB + 32'h20, 32'h1000, MB + 32'h02};
        logic        rw [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] re [11] = '{32'd0, 32'd2, 32'h2000_0000, 32'h1111_1111, 32'd0, 32'd4, 32'h1003,
                                 32'h1111_1111, 32'd0, 32'd0, 32'd0};
        drive(32'h0, 32'h1111_1111, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) begin
            if (i == 1) drive(32'h2000_0000, 32'hBADB_AD00, 1'b1, 1'b0);
            if (i == 4) drive(32'h1, 32'hFFFF_0000, 1'b1, 1'b0);
            exp_q.push_back(re[i]);
            drive(ra[i], 32'hEEEE_EEEE, rw[i], 1'b1);
            exp_v = exp_q.pop_front();
            n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL err_%0d got=%h exp=%h", i, mem_read_data, exp_v); end
        end
        exp_q.push_back(32'd7);
        drive(MB + 32'h14, 32'd0, 1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL err_count_final got=%h exp=%h", mem_read_data, exp_v); end
        exp_q.push_back(MB + 32'h02);
        drive(MB + 32'h18, 32'd0, 1'b0, 1'b1);
        exp_v = exp_q.pop_front();
        n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL err_addr_final got=%h exp=%h", mem_read_data, exp_v); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] exp_v;
        logic [31:0] ra [9] = '{MB, MB + 32'h08, MB + 32'h0C, MB + 32'h10, MB + 32'h14, MB + 32'h18, MB + 32'h1C, 32'h20, 32'h0};
        logic [31:0] re [9] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 32'h55AA_55AA, 32'h1111_1111};
        drive(32'h20, 32'h55AA_55AA, 1'b1, 1'b0);
        @(negedge clk);
        mem_address = 32'h20; mem_write_data = 32'hDEAD_0000; mem_write_en = 1'b1; mem_read_en = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        mem_write_en = 1'b0; mem_read_en = 1'b1;
        #1;
        n_checks++; if (mem_read_data !== 32'h55AA_55AA) begin n_fail++; $display("FAIL rstmid_ram_in_reset got=%h exp=55aa55aa", mem_read_data); end
        n_checks++; if (gpio_out !== 32'd0) begin n_fail++; $display("FAIL rstmid_gpio got=%h exp=0", gpio_out); end
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL rstmid_irq got=%b exp=0", timer_irq); end
        @(negedge clk);
        mem_read_en = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(re[i]);
            drive(ra[i], 32'd0, 1'b0, 1'b1);
            exp_v = exp_q.pop_front();
            n_checks++; if (mem_read_data !== exp_v) begin n_fail++; $display("FAIL rstmid_reg_%0d got=%h exp=%h", i, mem_read_data, exp_v); end
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        mem_address    = 32'd0;
        mem_write_data = 32'd0;
        mem_write_en   = 1'b0;
        mem_read_en    = 1'b0;
        test_reset();
        test_ram();
        test_gpio_ro();
        test_cycle_snapshot();
        test_timer();
        test_errors();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
